// File: rtl/sos_run_arbiter.sv
// sos_run_arbiter: round-robin owner of one shared Start_Sig/Done_Sig pattern generator.
// Optional run-timeout abort is compiled in when SOS_ARB_TIMEOUT_EN is defined.
module sos_run_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                       CLK,
    input  logic                       RSTn,
    input  logic [NUM_REQ-1:0]         Req_Sig,
    input  logic                       Done_Sig,
    output logic                       Start_Sig,
    output logic [NUM_REQ-1:0]         Ack_Sig,
    output logic [$clog2(NUM_REQ)-1:0] Grant_Id,
    output logic                       Busy_Sig,
    output logic                       Err_Sig,
    output logic [1:0]                 State_Dbg
);

    // Handshake: each Req_Sig bit is a level held by its source until that
    // bit of Ack_Sig pulses; Ack_Sig marks run completion, not acceptance.
    localparam int IDW = $clog2(NUM_REQ);
    localparam int IXW = IDW + 1;
    localparam int GCW = $clog2(GAP_CYCLES) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [GCW-1:0]     gap_q, gap_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [IDW-1:0]     pick_id;
    logic               pick_vld;
    logic [IXW-1:0]     idx;
    logic               timeout_hit;

    // Scan from the highest offset down so the lowest offset from ptr_q wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        idx      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr_q} + IXW'(i);
            if (idx >= IXW'(NUM_REQ)) begin
                idx = idx - IXW'(NUM_REQ);
            end
            if (Req_Sig[idx[IDW-1:0]]) begin
                pick_vld = 1'b1;
                pick_id  = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        gap_d   = gap_q;
        ack_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_id;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Done_Sig takes precedence over a timeout on the same edge.
                if (Done_Sig || timeout_hit) begin
                    state_d = ST_GAP;
                    gap_d   = GCW'(GAP_CYCLES);
                    ptr_d   = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);
                    if (Done_Sig) begin
                        ack_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GCW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            gap_q   <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            gap_q   <= gap_d;
            ack_q   <= ack_d;
        end
    end

`ifdef SOS_ARB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TCW-1:0] run_cnt_q;
    logic           err_q;

    assign timeout_hit = (state_q == ST_RUN) && (run_cnt_q == TCW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            run_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= timeout_hit && !Done_Sig;
            if ((state_q == ST_RUN) && !Done_Sig && !timeout_hit) begin
                run_cnt_q <= run_cnt_q + TCW'(1);
            end else begin
                run_cnt_q <= '0;
            end
        end
    end

    assign Err_Sig = err_q;
`else
    assign timeout_hit = 1'b0;
    // Always 0 for any legal TIMEOUT_CYCLES; RUN waits for Done_Sig indefinitely.
    assign Err_Sig     = (TIMEOUT_CYCLES < 1);
`endif

    // Start_Sig decodes the state register so reset drops it asynchronously.
    assign Start_Sig = (state_q == ST_RUN);
    assign Busy_Sig  = (state_q != ST_IDLE);
    assign Ack_Sig   = ack_q;
    assign Grant_Id  = grant_q;
    assign State_Dbg = state_q;

endmodule

// File: tb/tb_sos_run_arbiter.sv
// tb_sos_run_arbiter: vector table plus grant scoreboard for sos_run_arbiter,
// with a Done_Sig model that answers RUN_LEN cycles after Start_Sig rises.
`timescale 1ns/1ps
module tb_sos_run_arbiter;

    localparam int NUM_REQ = 4;
    localparam int GAP     = 8;
    localparam int TMO     = 100;
    localparam int RUN_LEN = 20;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic [3:0] Req_Sig = 4'b0000;
    logic       Done_Sig;
    logic       Start_Sig;
    logic [3:0] Ack_Sig;
    logic [1:0] Grant_Id;
    logic       Busy_Sig;
    logic       Err_Sig;
    logic [1:0] State_Dbg;
    logic [10:0] outs_all;

    sos_run_arbiter #(
        .NUM_REQ(NUM_REQ),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK(CLK),
        .RSTn(RSTn),
        .Req_Sig(Req_Sig),
        .Done_Sig(Done_Sig),
        .Start_Sig(Start_Sig),
        .Ack_Sig(Ack_Sig),
        .Grant_Id(Grant_Id),
        .Busy_Sig(Busy_Sig),
        .Err_Sig(Err_Sig),
        .State_Dbg(State_Dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    assign outs_all = {Start_Sig, Ack_Sig, Grant_Id, Busy_Sig, Err_Sig, State_Dbg};

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];
    logic [1:0] cur_exp = 2'd0;
    bit  prev_start = 0, run_open = 0, last_end_valid = 0;
    bit  chk_gap = 0, chk_lat = 0;
    bit  done_en = 1, model_done = 0, stray_done = 0;
    int  run_cycles = 0, done_dly = RUN_LEN;
    int  req_cyc = 0, last_start_cyc = 0, last_end_cyc = 0, err_cyc = 0;
    int  ack_count = 0, err_count = 0, start_count = 0;

    assign Done_Sig = model_done | stray_done;

    function automatic void chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Done model and output monitor, both on the falling edge.
    always @(negedge CLK) begin
        if (!RSTn) begin
            prev_start     = 0;
            run_open       = 0;
            last_end_valid = 0;
            run_cycles     = 0;
            model_done     = 0;
        end else begin
            if (Start_Sig) run_cycles++; else run_cycles = 0;
            model_done = done_en && Start_Sig && (run_cycles == done_dly);

            if (Start_Sig && !prev_start) begin
                if (exp_q.size() == 0) begin
                    chk(0, "grant_unexpected", Grant_Id, -1);
                end else begin
                    cur_exp = exp_q.pop_front();
                    chk(Grant_Id == cur_exp, "grant_id", Grant_Id, cur_exp);
                end
                chk(Busy_Sig == 1'b1, "busy_in_run", Busy_Sig, 1);
                if (chk_gap && last_end_valid)
                    chk(cyc - last_end_cyc == GAP + 2, "gap_len", cyc - last_end_cyc, GAP + 2);
                if (chk_lat) begin
                    chk(cyc - req_cyc == 1, "req_to_start", cyc - req_cyc, 1);
                    chk_lat = 0;
                end
                run_open       = 1;
                last_start_cyc = cyc;
                start_count++;
            end

            if (Ack_Sig != 4'b0000) begin
                chk(run_open && (Ack_Sig == (4'b0001 << cur_exp)), "ack_match", Ack_Sig, 4'b0001 << cur_exp);
                chk(Start_Sig == 1'b0, "start_low_at_ack", Start_Sig, 0);
                chk(cyc - last_start_cyc == done_dly, "run_len", cyc - last_start_cyc, done_dly);
                run_open       = 0;
                last_end_cyc   = cyc;
                last_end_valid = 1;
                ack_count++;
            end

            if (Err_Sig) begin
                err_count++;
                err_cyc        = cyc;
                run_open       = 0;
                last_end_cyc   = cyc;
                last_end_valid = 1;
            end
            prev_start = Start_Sig;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        RSTn       = 1'b0;
        Req_Sig    = 4'b0000;
        stray_done = 0;
        repeat (3) tick();
        exp_q.delete();
        RSTn = 1'b1;
    endtask

    task automatic wait_acks(input int target, input int budget);
        int n = 0;
        while (ack_count < target && n < budget) begin tick(); n++; end
        chk(ack_count >= target, "ack_wait", ack_count, target);
    endtask

    task automatic wait_starts(input int target, input int budget);
        int n = 0;
        while (start_count < target && n < budget) begin tick(); n++; end
        chk(start_count >= target, "start_wait", start_count, target);
    endtask

    task automatic wait_errs(input int target, input int budget);
        int n = 0;
        while (err_count < target && n < budget) begin tick(); n++; end
        chk(err_count >= target, "err_wait", err_count, target);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (Busy_Sig && n < budget) begin tick(); n++; end
        chk(Busy_Sig == 1'b0, "idle_wait", Busy_Sig, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] req;
        int         n;
        logic [1:0] g [6];
    } vec_t;

    function automatic vec_t mk(input logic [3:0] req, input int n,
                                input int a, input int b, input int c,
                                input int d, input int e, input int f);
        vec_t v;
        v.req  = req;
        v.n    = n;
        v.g[0] = 2'(a); v.g[1] = 2'(b); v.g[2] = 2'(c);
        v.g[3] = 2'(d); v.g[4] = 2'(e); v.g[5] = 2'(f);
        return v;
    endfunction

    vec_t vecs [5];

    initial begin
        int base_a, base_s, base_e;

        vecs[0] = mk(4'b0100, 1, 2, 0, 0, 0, 0, 0);
        vecs[1] = mk(4'b1011, 6, 0, 1, 3, 0, 1, 3);
        vecs[2] = mk(4'b1000, 2, 3, 3, 0, 0, 0, 0);
        vecs[3] = mk(4'b1111, 5, 0, 1, 2, 3, 0, 0);
        vecs[4] = mk(4'b0110, 3, 1, 2, 1, 0, 0, 0);

        // Reset values, quiet idle, stray Done ignored.
        RSTn = 1'b0;
        repeat (3) tick();
        chk(outs_all == 11'd0, "reset_values", outs_all, 0);
        RSTn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk(outs_all == 11'd0, "idle_quiet", outs_all, 0);
        end
        stray_done = 1;
        tick();
        stray_done = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk(outs_all == 11'd0, "stray_done", outs_all, 0);
        end

        // Table: each row starts from reset (pointer 0) and holds its request pattern.
        for (int r = 0; r < 5; r++) begin
            do_reset();
            chk_gap = 1;
            for (int k = 0; k < vecs[r].n; k++) exp_q.push_back(vecs[r].g[k]);
            base_a  = ack_count;
            req_cyc = cyc;
            chk_lat = 1;
            Req_Sig = vecs[r].req;
            wait_acks(base_a + vecs[r].n, vecs[r].n * (RUN_LEN + GAP + 4) + 10);
            Req_Sig = 4'b0000;
            wait_idle(50);
            chk(exp_q.size() == 0, "grants_left", exp_q.size(), 0);
            chk_gap = 0;
        end

        // Requester drops mid-run: run completes and is still acknowledged.
        do_reset();
        exp_q.push_back(2'd1);
        base_s  = start_count;
        base_a  = ack_count;
        Req_Sig = 4'b0010;
        wait_starts(base_s + 1, 10);
        repeat (5) tick();
        Req_Sig = 4'b0000;
        wait_acks(base_a + 1, 60);
        wait_idle(50);
        repeat (5) tick();
        chk(start_count == base_s + 1, "no_regrant", start_count, base_s + 1);

        // Reset mid-run drops Start without a clock edge; arbitration restarts.
        do_reset();
        exp_q.push_back(2'd0);
        base_s  = start_count;
        Req_Sig = 4'b0001;
        wait_starts(base_s + 1, 10);
        repeat (5) tick();
        #1;
        RSTn = 1'b0;
        #1;
        chk(Start_Sig == 1'b0, "async_start_drop", Start_Sig, 0);
        chk(Busy_Sig == 1'b0, "async_busy_drop", Busy_Sig, 0);
        chk(Ack_Sig == 4'b0000, "no_ack_on_reset", Ack_Sig, 0);
        Req_Sig = 4'b1000;
        exp_q.delete();
        exp_q.push_back(2'd3);
        repeat (2) tick();
        base_a = ack_count;
        RSTn   = 1'b1;
        wait_acks(base_a + 1, 80);
        Req_Sig = 4'b0000;
        wait_idle(50);

`ifdef SOS_ARB_TIMEOUT_EN
        // No Done: Err after TMO cycles, no Ack, next pending index served.
        do_reset();
        done_en = 0;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd2);
        base_s  = start_count;
        base_a  = ack_count;
        base_e  = err_count;
        Req_Sig = 4'b0101;
        wait_starts(base_s + 1, 10);
        wait_errs(base_e + 1, TMO + 20);
        chk(err_cyc - last_start_cyc == TMO, "timeout_len", err_cyc - last_start_cyc, TMO);
        chk(ack_count == base_a, "no_ack_on_timeout", ack_count, base_a);
        done_en = 1;
        wait_acks(base_a + 1, 80);
        Req_Sig = 4'b0000;
        wait_idle(50);

        // Done on the timeout edge wins.
        do_reset();
        done_dly = TMO;
        exp_q.push_back(2'd0);
        base_a  = ack_count;
        base_e  = err_count;
        Req_Sig = 4'b0001;
        wait_acks(base_a + 1, TMO + 20);
        Req_Sig = 4'b0000;
        repeat (3) tick();
        chk(err_count == base_e, "no_err_when_done", err_count, base_e);
        wait_idle(50);
        done_dly = RUN_LEN;
`else
        // No Done and no timeout: Start stays high, Err never pulses.
        do_reset();
        done_en = 0;
        exp_q.push_back(2'd0);
        base_s  = start_count;
        base_e  = err_count;
        Req_Sig = 4'b0001;
        wait_starts(base_s + 1, 10);
        for (int i = 1; i <= 1000; i++) begin
            tick();
            if (i % 100 == 0) chk(Start_Sig == 1'b1, "start_held", Start_Sig, 1);
        end
        chk(err_count == base_e, "err_stays_low", err_count, base_e);
        do_reset();
        done_en = 1;
`endif

        chk(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #1ms;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
